// File: rtl/multiplicador_secuencial.sv
// Shift-and-add unsigned multiplier: one BITS-wide ripple adder reused over BITS cycles.
// Includes the ripple-carry adder (sumador) and its full-adder cell.

module sumador_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module sumador #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] num1,
  input  logic [BITS-1:0] num2,
  input  logic            Cin,
  output logic [BITS-1:0] sum,
  output logic            Cout
);
  logic [BITS:0] c;

  assign c[0] = Cin;

  sumador_fa u_fa [BITS-1:0] (
    .a (num1),
    .b (num2),
    .ci(c[BITS-1:0]),
    .s (sum),
    .co(c[BITS:1])
  );

  assign Cout = c[BITS];
endmodule

module multiplicador_secuencial #(
  parameter int BITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BITS-1:0]   num1,
  input  logic [BITS-1:0]   num2,
  output logic              busy,
  output logic              done,
  output logic [2*BITS-1:0] Resul
);
  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t          state;
  logic [BITS-1:0] m_r, a_r, q_r;
  logic [CW-1:0]   cnt;

  logic [BITS-1:0] sum, p;
  logic            cout, p_c;
  logic [BITS-1:0] a_nxt, q_nxt;
  logic            last;

  sumador #(.BITS(BITS)) u_sum (
    .num1(a_r),
    .num2(m_r),
    .Cin (1'b0),
    .sum (sum),
    .Cout(cout)
  );

  // Partial keeps the adder carry so it shifts into A instead of being lost.
  always_comb begin
    p_c = 1'b0;
    p   = a_r;
    if (q_r[0]) begin
      p_c = cout;
      p   = sum;
    end
  end

  assign a_nxt = {p_c, p[BITS-1:1]};
  assign q_nxt = {p[0], q_r[BITS-1:1]};
  assign last  = (cnt == CW'(BITS-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      m_r   <= '0;
      a_r   <= '0;
      q_r   <= '0;
      cnt   <= '0;
      Resul <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_r   <= num1;
            q_r   <= num2;
            a_r   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          a_r <= a_nxt;
          q_r <= q_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            Resul <= {a_nxt, q_nxt};
            done  <= 1'b1;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Directed bench for multiplicador_secuencial at BITS=4 and BITS=8.

module tb_multiplicador_secuencial;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic [3:0] num1_4 = '0, num2_4 = '0;
  logic       busy4, done4;
  logic [7:0] Resul4;

  logic        start8 = 1'b0;
  logic [7:0]  num1_8 = '0, num2_8 = '0;
  logic        busy8, done8;
  logic [15:0] Resul8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multiplicador_secuencial #(.BITS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .num1(num1_4), .num2(num2_4),
    .busy(busy4), .done(done4), .Resul(Resul4)
  );

  multiplicador_secuencial #(.BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .num1(num1_8), .num2(num2_8),
    .busy(busy8), .done(done8), .Resul(Resul8)
  );

  // Launch one BITS=4 operation and observe a fixed 10-cycle window.
  task automatic mul4(input logic [3:0] a, input logic [3:0] b,
                      output logic [7:0] res, output int lat,
                      output int bcnt, output int dcnt);
    @(negedge clk);
    start4 = 1'b1; num1_4 = a; num2_4 = b;
    @(negedge clk);
    start4 = 1'b0; num1_4 = ~a; num2_4 = ~b;
    res = '0; lat = -1; bcnt = 0; dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      num1_4 = num1_4 + 4'd3;
      if (busy4) bcnt++;
      if (done4) begin
        dcnt++;
        if (lat < 0) begin lat = k; res = Resul4; end
      end
    end
  endtask

  task automatic mul8(input logic [7:0] a, input logic [7:0] b,
                      output logic [15:0] res, output int lat);
    @(negedge clk);
    start8 = 1'b1; num1_8 = a; num2_8 = b;
    @(negedge clk);
    start8 = 1'b0; num1_8 = 8'h5A; num2_8 = 8'hC3;
    res = '0; lat = -1;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge clk);
      if (done8 && lat < 0) begin lat = k; res = Resul8; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || Resul4 !== 8'd0) begin
      bad++;
      $display("FAIL reset4: busy=%b done=%b Resul=%0d, want 0 0 0", busy4, done4, Resul4);
    end
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || Resul8 !== 16'd0) begin
      bad++;
      $display("FAIL reset8: busy=%b done=%b Resul=%0d, want 0 0 0", busy8, done8, Resul8);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] r; int lat, bc, dc;
    mul4(4'd3, 4'd5, r, lat, bc, dc);
    total++;
    if (r !== 8'd15) begin bad++; $display("FAIL basic_3x5: got %0d want 15", r); end
    total++;
    if (lat !== 4) begin bad++; $display("FAIL basic_latency: got %0d want 4", lat); end
    total++;
    if (bc !== 5) begin bad++; $display("FAIL basic_busy_cycles: got %0d want 5", bc); end
    total++;
    if (dc !== 1) begin bad++; $display("FAIL basic_done_width: got %0d want 1", dc); end
  endtask

  task automatic test_corners;
    logic [7:0] r; int lat, bc, dc;
    mul4(4'd15, 4'd15, r, lat, bc, dc);
    total++;
    if (r !== 8'hE1 || lat !== 4) begin
      bad++; $display("FAIL corner_15x15: got %0d lat %0d want 225 lat 4", r, lat);
    end
    mul4(4'd0, 4'd13, r, lat, bc, dc);
    total++;
    if (r !== 8'd0 || lat !== 4) begin
      bad++; $display("FAIL corner_0x13: got %0d lat %0d want 0 lat 4", r, lat);
    end
    mul4(4'd15, 4'd1, r, lat, bc, dc);
    total++;
    if (r !== 8'd15 || lat !== 4) begin
      bad++; $display("FAIL corner_15x1: got %0d lat %0d want 15 lat 4", r, lat);
    end
  endtask

  // start held high; operands change every cycle. Accepts land on drive
  // indices 0,6,12,... and each done shows up 5 negedges after its drive.
  task automatic test_back_to_back;
    logic [3:0] ha [0:31];
    logic [3:0] hb [0:31];
    int next_done = 5;
    int dones = 0;
    logic prev_done = 1'b0;
    logic [7:0] want;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (done4) begin
        dones++;
        want = 8'(ha[i-5]) * 8'(hb[i-5]);
        total++;
        if (i !== next_done || Resul4 !== want) begin
          bad++;
          $display("FAIL b2b_done: at %0d Resul=%0d, want at %0d Resul=%0d", i, Resul4, next_done, want);
        end
        next_done = i + 6;
      end
      if (done4 && prev_done) begin
        total++; bad++;
        $display("FAIL b2b_done_twice: done high two cycles at %0d", i);
      end
      prev_done = done4;
      ha[i] = 4'((i + 3) % 16);
      hb[i] = 4'((i * 5 + 7) % 16);
      start4 = 1'b1; num1_4 = ha[i]; num2_4 = hb[i];
    end
    start4 = 1'b0;
    total++;
    if (dones !== 5) begin bad++; $display("FAIL b2b_count: got %0d want 5", dones); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [7:0] r; int lat, bc, dc;
    int seen = 0;
    @(negedge clk);
    start4 = 1'b1; num1_4 = 4'd7; num2_4 = 4'd9;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy4 !== 1'b0 || Resul4 !== 8'd0 || done4 !== 1'b0) begin
      bad++; $display("FAIL midreset_clear: busy=%b Resul=%0d done=%b want 0 0 0", busy4, Resul4, done4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done4) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midreset_no_done: got %0d dones want 0", seen); end
    mul4(4'd7, 4'd9, r, lat, bc, dc);
    total++;
    if (r !== 8'd63 || lat !== 4) begin
      bad++; $display("FAIL midreset_7x9: got %0d lat %0d want 63 lat 4", r, lat);
    end
  endtask

  task automatic test_hold;
    logic [7:0] r; int lat, bc, dc;
    int diffs = 0;
    mul4(4'd6, 4'd11, r, lat, bc, dc);
    total++;
    if (r !== 8'd66) begin bad++; $display("FAIL hold_6x11: got %0d want 66", r); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      num1_4 = 4'(k); num2_4 = 4'(15 - k);
      if (Resul4 !== 8'd66) diffs++;
    end
    total++;
    if (diffs !== 0) begin bad++; $display("FAIL hold_resul: changed %0d times, Resul=%0d want 66", diffs, Resul4); end
  endtask

  task automatic test_bits8;
    logic [15:0] r; int lat;
    logic [7:0] a, b;
    int errs = 0;
    mul8(8'd255, 8'd255, r, lat);
    total++;
    if (r !== 16'd65025 || lat !== 8) begin
      bad++; $display("FAIL b8_255x255: got %0d lat %0d want 65025 lat 8", r, lat);
    end
    mul8(8'd200, 8'd3, r, lat);
    total++;
    if (r !== 16'd600 || lat !== 8) begin
      bad++; $display("FAIL b8_200x3: got %0d lat %0d want 600 lat 8", r, lat);
    end
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      mul8(a, b, r, lat);
      if (r !== 16'(a) * 16'(b) || lat !== 8) begin
        errs++;
        if (errs <= 5)
          $display("FAIL b8_rand: %0d*%0d got %0d lat %0d want %0d lat 8", a, b, r, lat, 16'(a) * 16'(b));
      end
    end
    total++;
    if (errs !== 0) begin bad++; $display("FAIL b8_rand_total: %0d errors want 0", errs); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    test_bits8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
